motor_ramp_controller: RTL
==========================

MOTOR_RAMP_CONTROLLER -- requirements
Module: motor_ramp_controller

Interface
REQ-001 Parameter TICK_DIV, default 50000, SHALL set CLOCK_50 cycles per ramp tick (1 ms).
REQ-002 Parameter STEP_UP, default 4, SHALL set the duty increment per tick.
REQ-003 Parameter STEP_DOWN, default 16, SHALL set the duty decrement per tick.
REQ-004 Parameter DEADBAND, default 12, SHALL set the threshold: any target <= DEADBAND is treated as 0.
REQ-005 CLOCK_50  in  1  SHALL be the single system clock, 50 MHz, rising edge.
REQ-006 reset  in  1  SHALL be the reset: asynchronous, active-high.
REQ-007 enable  in  1  SHALL enable the motor: 1 = run, 0 = ramp to stop.
REQ-008 brake  in  1  SHALL be the immediate-stop request (level).
REQ-009 cmd_valid  in  1  SHALL be a one-cycle strobe qualifying target.
REQ-010 target  in  10  SHALL be the requested duty from the filter module (0..1023).
REQ-011 pwm_cmd  out  10  SHALL be the registered duty command feeding the PWM generator input.
REQ-012 state  out  2  SHALL be the current FSM state: IDLE=0, RAMP=1, HOLD=2, BRAKE=3.
REQ-013 ramping  out  1  SHALL be high while state==RAMP.

Function
REQ-014 The tick counter SHALL count 0..TICK_DIV-1 and wrap; tick SHALL pulse for one cycle when count==TICK_DIV-1.
REQ-015 On cmd_valid, target SHALL be latched into tgt on that edge; with no strobe, tgt SHALL hold.
REQ-016 tgt_eff SHALL be 0 when enable==0 or tgt<=DEADBAND, else tgt.
REQ-017 If cmd_valid and tick coincide, the step SHALL use the old tgt; the new value SHALL apply from the next tick.
REQ-018 Up-step SHALL be pwm_cmd = min(pwm_cmd+STEP_UP, tgt_eff), computed at 11 bits with no wrap past 1023.
REQ-019 Down-step SHALL be pwm_cmd = max(pwm_cmd-STEP_DOWN, tgt_eff), computed signed/11-bit with no underflow below 0.
REQ-020 pwm_cmd SHALL change only on a tick in RAMP, on brake entry, or on reset.
REQ-021 IDLE: pwm_cmd==0. The FSM SHALL go to RAMP when tgt_eff!=0.
REQ-022 RAMP: the FSM SHALL step on each tick, go to HOLD on the edge where the updated pwm_cmd equals a nonzero tgt_eff, and go to IDLE when the updated pwm_cmd reaches 0 with tgt_eff==0.
REQ-023 HOLD: the FSM SHALL return to RAMP on the cycle after tgt_eff!=pwm_cmd.
REQ-024 brake==1 in any state SHALL force BRAKE and pwm_cmd=0 on the next edge (highest priority).
REQ-025 BRAKE: pwm_cmd SHALL stay 0. On brake==0 the FSM SHALL go to IDLE, then re-ramp from 0 per REQ-021.
REQ-026 The tick counter SHALL free-run in all states; it SHALL NOT be reset by state changes.

Reset
REQ-027 reset SHALL asynchronously clear pwm_cmd=0, tgt=0, tick counter=0, state=IDLE, ramping=0, including mid-ramp.
REQ-028 After reset deasserts, the first tick SHALL occur TICK_DIV cycles later.

Structure
REQ-029 The shared package motor_pkg SHALL hold the state encodings, the 10-bit duty width constant and the parameter defaults.
REQ-030 The tick divider SHALL be the sub-module motor_tick_gen (params TICK_DIV; ports CLOCK_50, reset, tick).
REQ-031 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Verification (bench TICK_DIV=4)
REQ-032 Up-ramp: enable=1, target=100 strobed -> pwm_cmd 4,8,...,100 after 25 ticks; ramping high throughout; then state HOLD.
REQ-033 Down-ramp: from HOLD at 100, target=20 -> pwm_cmd 84,68,52,36,20 on 5 ticks; then HOLD.
REQ-034 Deadband/saturation: target=10 from 36 -> 20,4,0 then IDLE. target=1023 -> final step 1020->1023 with no wrap.
REQ-035 Brake: brake=1 at pwm_cmd=40 mid-ramp -> next edge pwm_cmd=0, state=3. Release -> IDLE, then RAMP 4,8,...
REQ-036 Reset: reset pulsed asynchronously between edges at pwm_cmd=60 -> outputs 0/IDLE immediately. First tick exactly 4 cycles after release.

Source files
------------

// File: rtl/motor_pkg.sv
// Shared definitions for the motor ramp controller: FSM encodings, duty width
// and parameter defaults.
package motor_pkg;

  localparam int DUTY_W        = 10;
  localparam int DUTY_MAX      = (1 << DUTY_W) - 1;

  localparam int TICK_DIV_DEF  = 50000;
  localparam int STEP_UP_DEF   = 4;
  localparam int STEP_DOWN_DEF = 16;
  localparam int DEADBAND_DEF  = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RAMP  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_BRAKE = 2'd3
  } motor_state_t;

endpackage

// File: rtl/motor_tick_gen.sv
// Free-running ramp tick divider: one-cycle tick every TICK_DIV clocks,
// counter cleared only by reset.
module motor_tick_gen
  import motor_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic CLOCK_50,
  input  logic reset,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (count_reg == LAST) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + 1'b1;
    end
  end

  // Decoded from a register, so the tick is clean and lands on the last count.
  assign tick = (count_reg == LAST);

endmodule

// File: rtl/motor_ramp_controller.sv
// Slew-limited duty command for a motor PWM stage: ramps toward the latched
// target at separate up/down rates, with deadband, hold and brake handling.
module motor_ramp_controller
  import motor_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int STEP_UP   = STEP_UP_DEF,
  parameter int STEP_DOWN = STEP_DOWN_DEF,
  parameter int DEADBAND  = DEADBAND_DEF
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic              brake,
  input  logic              cmd_valid,
  input  logic [DUTY_W-1:0] target,
  output logic [DUTY_W-1:0] pwm_cmd,
  output logic [1:0]        state,
  output logic              ramping
);

  logic              tick;
  logic [DUTY_W-1:0] tgt_reg;
  logic [DUTY_W-1:0] pwm_cmd_reg, pwm_cmd_next;
  motor_state_t      state_reg, state_next;
  logic              ramping_reg;

  logic [DUTY_W-1:0] tgt_eff;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W-1:0] up_sat, up_val;
  logic signed [DUTY_W:0] dn_diff;
  logic [DUTY_W-1:0] dn_sat, dn_val, step_val;

  motor_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .tick     (tick)
  );

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      tgt_reg <= '0;
    end else if (cmd_valid) begin
      tgt_reg <= target;
    end
  end

  assign tgt_eff = (!enable || (tgt_reg <= DUTY_W'(DEADBAND))) ? '0 : tgt_reg;

  // One extra bit on each side keeps the step from wrapping past full scale or below zero.
  always_comb begin
    up_sum  = {1'b0, pwm_cmd_reg} + (DUTY_W+1)'(STEP_UP);
    up_sat  = (up_sum > (DUTY_W+1)'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : up_sum[DUTY_W-1:0];
    up_val  = (up_sat > tgt_eff) ? tgt_eff : up_sat;
    dn_diff = $signed({1'b0, pwm_cmd_reg}) - $signed((DUTY_W+1)'(STEP_DOWN));
    dn_sat  = (dn_diff < 0) ? '0 : dn_diff[DUTY_W-1:0];
    dn_val  = (dn_sat < tgt_eff) ? tgt_eff : dn_sat;
    if (pwm_cmd_reg < tgt_eff) begin
      step_val = up_val;
    end else if (pwm_cmd_reg > tgt_eff) begin
      step_val = dn_val;
    end else begin
      step_val = pwm_cmd_reg;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pwm_cmd_next = pwm_cmd_reg;
    if (brake) begin
      state_next   = ST_BRAKE;
      pwm_cmd_next = '0;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          if (tgt_eff != '0) state_next = ST_RAMP;
        end
        ST_RAMP: begin
          if (tick) begin
            pwm_cmd_next = step_val;
            if ((tgt_eff != '0) && (step_val == tgt_eff)) begin
              state_next = ST_HOLD;
            end else if ((tgt_eff == '0) && (step_val == '0)) begin
              state_next = ST_IDLE;
            end
          end
        end
        ST_HOLD: begin
          if (tgt_eff != pwm_cmd_reg) state_next = ST_RAMP;
        end
        ST_BRAKE: begin
          pwm_cmd_next = '0;
          state_next   = ST_IDLE;
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      pwm_cmd_reg <= '0;
      ramping_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pwm_cmd_reg <= pwm_cmd_next;
      ramping_reg <= (state_next == ST_RAMP);
    end
  end

  assign pwm_cmd = pwm_cmd_reg;
  assign state   = state_reg;
  assign ramping = ramping_reg;

endmodule
